// File: rtl/riscv_commit_checker.sv
// Commit checker: watches register-file writebacks and compares them in order
// against a programmed table of expected (rd, data) pairs.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | table writable, waiting for start
// S_RUN     | matching writebacks against the table, counting cycles
// S_PASS    | every active entry matched in order
// S_FAIL    | data mismatch (or, when STRICT, an unexpected rd)
// S_TIMEOUT | RUN budget used up before a verdict
module riscv_commit_checker #(
    parameter int XLEN           = 32,
    parameter int NUM_CHECKS     = 8,
    parameter int IDX_W          = 3,
    parameter int TIMEOUT_CYCLES = 30,
    parameter int CNT_W          = 16,
    parameter int STRICT         = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exp_we,
    input  logic [IDX_W-1:0] exp_idx,
    input  logic [4:0]       exp_rd,
    input  logic [XLEN-1:0]  exp_data,
    input  logic [IDX_W:0]   chk_count,
    input  logic             start,
    input  logic             clear,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [IDX_W-1:0] fail_idx,
    output logic [4:0]       fail_rd,
    output logic [XLEN-1:0]  fail_data,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] wb_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [IDX_W:0]   NUM_CHECKS_C = (IDX_W+1)'(NUM_CHECKS);
    localparam logic [CNT_W-1:0] TO_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;
    logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
    logic [4:0]       fail_rd_q, fail_rd_d;
    logic [XLEN-1:0]  fail_data_q, fail_data_d;
    logic [4:0]       exp_rd_q   [NUM_CHECKS];
    logic [4:0]       exp_rd_d   [NUM_CHECKS];
    logic [XLEN-1:0]  exp_data_q [NUM_CHECKS];
    logic [XLEN-1:0]  exp_data_d [NUM_CHECKS];

    logic count_ok;
    logic last_entry;
    logic wb_live;
    logic verdict;

    // Next-state, table write, matching and counter logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        cycle_cnt_d = cycle_cnt_q;
        wb_cnt_d    = wb_cnt_q;
        fail_idx_d  = fail_idx_q;
        fail_rd_d   = fail_rd_q;
        fail_data_d = fail_data_q;
        exp_rd_d    = exp_rd_q;
        exp_data_d  = exp_data_q;
        verdict     = 1'b0;

        // A latched count of 0 or above the table depth means "nothing to check".
        count_ok   = (count_q != '0) && (count_q <= NUM_CHECKS_C);
        last_entry = ({1'b0, ptr_q} == (count_q - 1'b1));
        wb_live    = wb_en && (wb_rd != 5'd0);

        case (state_q)
            S_IDLE: begin
                if (exp_we && ({1'b0, exp_idx} < NUM_CHECKS_C)) begin
                    exp_rd_d[exp_idx]   = exp_rd;
                    exp_data_d[exp_idx] = exp_data;
                end
                if (start) begin
                    count_d     = chk_count;
                    ptr_d       = '0;
                    cycle_cnt_d = '0;
                    wb_cnt_d    = '0;
                    fail_idx_d  = '0;
                    fail_rd_d   = '0;
                    fail_data_d = '0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (wb_live && (wb_cnt_q != CNT_MAX)) begin
                    wb_cnt_d = wb_cnt_q + 1'b1;
                end
                if (!count_ok) begin
                    state_d = S_PASS;
                    verdict = 1'b1;
                end else if (wb_live) begin
                    if (wb_rd == exp_rd_q[ptr_q]) begin
                        if (wb_data == exp_data_q[ptr_q]) begin
                            if (last_entry) begin
                                state_d = S_PASS;
                                verdict = 1'b1;
                            end else begin
                                ptr_d = ptr_q + 1'b1;
                            end
                        end else begin
                            state_d     = S_FAIL;
                            verdict     = 1'b1;
                            fail_idx_d  = ptr_q;
                            fail_rd_d   = wb_rd;
                            fail_data_d = wb_data;
                        end
                    end else if (STRICT != 0) begin
                        state_d     = S_FAIL;
                        verdict     = 1'b1;
                        fail_idx_d  = ptr_q;
                        fail_rd_d   = wb_rd;
                        fail_data_d = wb_data;
                    end
                end
                // Timeout freezes cycle_cnt at the last RUN cycle index; a verdict
                // in the same cycle takes precedence.
                if (!verdict && (cycle_cnt_q == TO_LAST)) begin
                    state_d    = S_TIMEOUT;
                    fail_idx_d = ptr_q;
                end else if (cycle_cnt_q != CNT_MAX) begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
            end
            S_PASS, S_FAIL, S_TIMEOUT: begin
                if (clear) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, diagnostics and expected-value table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            cycle_cnt_q <= '0;
            wb_cnt_q    <= '0;
            fail_idx_q  <= '0;
            fail_rd_q   <= '0;
            fail_data_q <= '0;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                exp_rd_q[i]   <= '0;
                exp_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            cycle_cnt_q <= cycle_cnt_d;
            wb_cnt_q    <= wb_cnt_d;
            fail_idx_q  <= fail_idx_d;
            fail_rd_q   <= fail_rd_d;
            fail_data_q <= fail_data_d;
            exp_rd_q    <= exp_rd_d;
            exp_data_q  <= exp_data_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign pass      = (state_q == S_PASS);
    assign fail      = (state_q == S_FAIL);
    assign timeout   = (state_q == S_TIMEOUT);
    assign done      = pass || fail || timeout;
    assign fail_idx  = fail_idx_q;
    assign fail_rd   = fail_rd_q;
    assign fail_data = fail_data_q;
    assign cycle_cnt = cycle_cnt_q;
    assign wb_cnt    = wb_cnt_q;

endmodule
